pipe_stage_buf: RTL and testbench

//  Parametrised elastic pipeline stage register for the five-stage CPU,

---
 rtl/pipe_stage_buf_if.sv | 17 +
 rtl/pipe_stage_buf.sv | 126 ++++++++++++
 tb/tb_pipe_stage_buf.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stage link carrying PC, payload, branch-delay flag and exception code.
// The master drives valid and the entry fields; the slave drives ready.
interface pipe_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int EXC_W  = 5
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] data;
  logic              bd;
  logic [EXC_W-1:0]  exc;

  modport master (output valid, output pc, output data, output bd, output exc, input  ready);
  modport slave  (input  valid, input  pc, input  data, input  bd, input  exc, output ready);
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic 2-entry skid stage between CPU pipeline stages; 1-cycle latency, 1 entry/cycle.
// Upstream ready is a flop that drops only when the skid entry is occupied, so it never depends on out ready.
module pipe_stage_buf #(
  parameter int              DATA_W   = 32,
  parameter int              PC_W     = 32,
  parameter int              EXC_W    = 5,
  parameter logic [PC_W-1:0] RESET_PC = 'h3000,
  parameter bit              KEEP_PC  = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               flush,
  pipe_stage_buf_if.slave    in_if,
  pipe_stage_buf_if.master   out_if,
  output logic [1:0]         count
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic              bd;
    logic [EXC_W-1:0]  exc;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam entry_t CLR_ENTRY = '{pc: RESET_PC, data: '0, bd: 1'b0, exc: '0};

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  entry_t in_ent;
  logic   in_rdy_q, in_rdy_d;
  logic   out_vld_q, out_vld_d;
  logic   push, pop;

  assign in_ent = '{pc: in_if.pc, data: in_if.data, bd: in_if.bd, exc: in_if.exc};
  assign push   = in_if.valid & in_rdy_q;
  assign pop    = out_vld_q & out_if.ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (req) begin
      state_d = EMPTY;
      head_d  = CLR_ENTRY;
      skid_d  = CLR_ENTRY;
    end else if (flush) begin
      // Bubble: head PC/BD may survive so a later exception can still form the EPC.
      state_d     = EMPTY;
      head_d.data = '0;
      head_d.exc  = '0;
      skid_d      = CLR_ENTRY;
      if (!KEEP_PC) begin
        head_d.pc = RESET_PC;
        head_d.bd = 1'b0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_ent;
            state_d = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = in_ent;
          end else if (push) begin
            skid_d  = in_ent;
            state_d = FULL;
          end else if (pop) begin
            head_d.data = '0;
            head_d.exc  = '0;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            skid_d  = CLR_ENTRY;
            state_d = ONE;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = CLR_ENTRY;
          skid_d  = CLR_ENTRY;
        end
      endcase
    end
    out_vld_d = (state_d != EMPTY);
    in_rdy_d  = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= EMPTY;
      head_q    <= CLR_ENTRY;
      skid_q    <= CLR_ENTRY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign in_if.ready  = in_rdy_q;
  assign out_if.valid = out_vld_q;
  assign out_if.pc    = head_q.pc;
  assign out_if.data  = head_q.data;
  assign out_if.bd    = head_q.bd;
  assign out_if.exc   = head_q.exc;
  assign count        = state_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: per-cycle vector table plus hand-written reset and ready-isolation sequences.
module tb_pipe_stage_buf;

  localparam logic [31:0] DKEY = 32'h5A5A_0000;

  logic       clk;
  logic       reset;
  logic       req;
  logic       flush;
  logic [1:0] count;
  int         n_pass;
  int         n_total;

  pipe_stage_buf_if #(.DATA_W(32), .PC_W(32), .EXC_W(5)) up_if ();
  pipe_stage_buf_if #(.DATA_W(32), .PC_W(32), .EXC_W(5)) dn_if ();

  pipe_stage_buf #(
    .DATA_W(32), .PC_W(32), .EXC_W(5), .RESET_PC(32'h3000), .KEEP_PC(1'b1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .flush  (flush),
    .in_if  (up_if),
    .out_if (dn_if),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] ipc;
    logic        ibd;
    logic [4:0]  iexc;
    logic        ordy;
    logic        rq;
    logic        fl;
    logic        ev;
    logic [31:0] epc;
    logic        ebd;
    logic [4:0]  eexc;
    logic [1:0]  ecnt;
    logic        erdy;
    logic        cpc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [31:0] ipc, logic ibd, logic [4:0] iexc, logic ordy,
                              logic rq, logic fl, logic ev, logic [31:0] epc, logic ebd,
                              logic [4:0] eexc, logic [1:0] ecnt, logic erdy, logic cpc);
    vec_t v;
    v.iv = iv; v.ipc = ipc; v.ibd = ibd; v.iexc = iexc; v.ordy = ordy; v.rq = rq; v.fl = fl;
    v.ev = ev; v.epc = epc; v.ebd = ebd; v.eexc = eexc; v.ecnt = ecnt; v.erdy = erdy; v.cpc = cpc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %h, expected %h", nm, idx, act, exp);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ipc, input logic ibd, input logic [4:0] iexc,
                       input logic ordy, input logic rq, input logic fl);
    up_if.valid  = iv;
    up_if.pc     = ipc;
    up_if.data   = ipc ^ DKEY;
    up_if.bd     = ibd;
    up_if.exc    = iexc;
    dn_if.ready  = ordy;
    req          = rq;
    flush        = fl;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Streaming
    vecs.push_back(mk(1, 32'h3000, 0, 0, 1, 0, 0,  1, 32'h3000, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h3004, 0, 0, 1, 0, 0,  1, 32'h3004, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h3008, 0, 0, 1, 0, 0,  1, 32'h3008, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,  0, 32'h0,    0, 0, 0, 1, 0));
    // Backpressure fill and drain
    vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0,  1, 32'h3000, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h3004, 0, 0, 0, 0, 0,  1, 32'h3000, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 32'h3008, 0, 0, 0, 0, 0,  1, 32'h3000, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,  1, 32'h3004, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,  0, 32'h0,    0, 0, 0, 1, 0));
    // Exception flush from FULL with a concurrent input
    vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 0, 0,  1, 32'h3000, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h3004, 0, 0, 0, 0, 0,  1, 32'h3000, 0, 0, 2, 0, 0));
    vecs.push_back(mk(1, 32'h300c, 0, 0, 0, 1, 0,  0, 32'h3000, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,  0, 32'h3000, 0, 0, 0, 1, 1));
    // Bubble flush keeps head PC/BD, also when already empty
    vecs.push_back(mk(1, 32'h3010, 1, 0, 0, 0, 0,  1, 32'h3010, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h3014, 0, 0, 1, 0, 1,  0, 32'h3010, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 32'h0,    0, 0, 0, 0, 0,  0, 32'h3010, 1, 0, 0, 1, 1));
    vecs.push_back(mk(0, 32'h0,    0, 0, 0, 0, 1,  0, 32'h3010, 1, 0, 0, 1, 1));
    // Exception code passes through on simultaneous push/pop
    vecs.push_back(mk(1, 32'h3018, 0, 0,  1, 0, 0, 1, 32'h3018, 0, 0,  1, 1, 0));
    vecs.push_back(mk(1, 32'h3020, 0, 10, 1, 0, 0, 1, 32'h3020, 0, 10, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0,  1, 0, 0, 0, 32'h0,    0, 0,  0, 1, 0));
    // Flush mid-FULL, accept on the next cycle; req outranks flush
    vecs.push_back(mk(1, 32'h3030, 0, 0, 0, 0, 0,  1, 32'h3030, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 32'h3034, 0, 0, 0, 0, 0,  1, 32'h3030, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 0, 0, 1,  0, 32'h3030, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 32'h3038, 0, 0, 1, 0, 0,  1, 32'h3038, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 0, 1, 1,  0, 32'h3000, 0, 0, 0, 1, 1));
    // Exception entries through the skid path keep their codes and order
    vecs.push_back(mk(1, 32'h3040, 0, 3, 0, 0, 0,  1, 32'h3040, 0, 3, 1, 1, 0));
    vecs.push_back(mk(1, 32'h3044, 1, 7, 0, 0, 0,  1, 32'h3040, 0, 3, 2, 0, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,  1, 32'h3044, 1, 7, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0,    0, 0, 1, 0, 0,  0, 32'h0,    0, 0, 0, 1, 0));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_count", -1, 32'(count), 32'd0);
    chk("rst_valid", -1, 32'(dn_if.valid), 32'd0);
    chk("rst_ready", -1, 32'(up_if.ready), 32'd1);
    chk("rst_pc",    -1, dn_if.pc, 32'h3000);
    chk("rst_exc",   -1, 32'(dn_if.exc), 32'd0);
    chk("rst_data",  -1, dn_if.data, 32'd0);

    foreach (vecs[i]) begin
      vec_t v;
      logic [31:0] edata;
      v = vecs[i];
      drive(v.iv, v.ipc, v.ibd, v.iexc, v.ordy, v.rq, v.fl);
      @(posedge clk);
      #1;
      edata = v.ev ? (v.epc ^ DKEY) : 32'd0;
      chk("valid", i, 32'(dn_if.valid), 32'(v.ev));
      chk("ready", i, 32'(up_if.ready), 32'(v.erdy));
      chk("count", i, 32'(count), 32'(v.ecnt));
      chk("exc",   i, 32'(dn_if.exc), 32'(v.eexc));
      chk("data",  i, dn_if.data, edata);
      if (v.ev || v.cpc) begin
        chk("pc", i, dn_if.pc, v.epc);
        chk("bd", i, 32'(dn_if.bd), 32'(v.ebd));
      end
      @(negedge clk);
    end

    // in_ready must not follow out_ready combinationally while FULL
    drive(1, 32'h3050, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 32'h3054, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 0, 0, 0);
    #1 chk("iso_ready_or0", 100, 32'(up_if.ready), 32'd0);
    dn_if.ready = 1'b1;
    #1 chk("iso_ready_or1", 101, 32'(up_if.ready), 32'd0);

    // Synchronous reset from FULL drops the concurrent push
    drive(1, 32'h3058, 0, 5'd4, 1, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rstfull_count", 102, 32'(count), 32'd0);
    chk("rstfull_valid", 102, 32'(dn_if.valid), 32'd0);
    chk("rstfull_ready", 102, 32'(up_if.ready), 32'd1);
    chk("rstfull_pc",    102, dn_if.pc, 32'h3000);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    chk("rstfull_after_valid", 103, 32'(dn_if.valid), 32'd0);
    chk("rstfull_after_exc",   103, 32'(dn_if.exc), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
